// File: rtl/sort_perm_unsorter.sv
// Inverse of the 4-input sorter: rebuilds the original order (a, b, c, d) from a
// sorted quadruple and a Lehmer-coded permutation index, one pool pick per clock.
module sort_perm_unsorter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] min,
  input  logic [W-1:0] midl,
  input  logic [W-1:0] midh,
  input  logic [W-1:0] max,
  input  logic [4:0]   perm,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [W-1:0] a,
  output logic [W-1:0] b,
  output logic [W-1:0] c,
  output logic [W-1:0] d
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t       state_q;
  logic [W-1:0] pool_q [4];
  logic [W-1:0] pool_d [4];
  logic [1:0]   d0_q, d1_q;
  logic         d2_q;
  logic [1:0]   k_q;
  logic [W-1:0] work_a_q, work_b_q, work_c_q;
  logic [W-1:0] a_q, b_q, c_q, d_q;
  logic         busy_q, done_q, err_q;

  logic         perm_ok;
  logic [1:0]   dig0, dig1;
  logic [4:0]   sub6, rem6;
  logic [1:0]   sel_idx;
  logic [W-1:0] pick;

  // Constant division by 6 and 2 as a compare/subtract ladder.
  always_comb begin
    perm_ok = (perm < 5'd24);
    if (perm >= 5'd18) begin
      dig0 = 2'd3; sub6 = 5'd18;
    end else if (perm >= 5'd12) begin
      dig0 = 2'd2; sub6 = 5'd12;
    end else if (perm >= 5'd6) begin
      dig0 = 2'd1; sub6 = 5'd6;
    end else begin
      dig0 = 2'd0; sub6 = 5'd0;
    end
    rem6 = perm - sub6;
    if (rem6 >= 5'd4)      dig1 = 2'd2;
    else if (rem6 >= 5'd2) dig1 = 2'd1;
    else                   dig1 = 2'd0;
  end

  // Pick the selected pool entry and close the gap it leaves behind.
  always_comb begin
    case (k_q)
      2'd0:    sel_idx = d0_q;
      2'd1:    sel_idx = d1_q;
      2'd2:    sel_idx = {1'b0, d2_q};
      default: sel_idx = 2'd0;
    endcase
    pick = pool_q[sel_idx];
    for (int i = 0; i < 3; i++) begin
      pool_d[i] = (2'(i) < sel_idx) ? pool_q[i] : pool_q[i+1];
    end
    pool_d[3] = pool_q[3];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      for (int i = 0; i < 4; i++) pool_q[i] <= '0;
      d0_q     <= '0;
      d1_q     <= '0;
      d2_q     <= 1'b0;
      k_q      <= '0;
      work_a_q <= '0;
      work_b_q <= '0;
      work_c_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      d_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_RUN: begin
          k_q <= k_q + 2'd1;
          case (k_q)
            2'd0: begin work_a_q <= pick; pool_q <= pool_d; end
            2'd1: begin work_b_q <= pick; pool_q <= pool_d; end
            2'd2: begin work_c_q <= pick; pool_q <= pool_d; end
            default: begin
              a_q     <= work_a_q;
              b_q     <= work_b_q;
              c_q     <= work_c_q;
              d_q     <= pool_q[0];
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          endcase
        end
        default: begin
          // The DONE cycle also accepts a new request, giving one result per 5 clocks.
          state_q <= S_IDLE;
          if (start) begin
            if (!perm_ok) begin
              err_q <= 1'b1;
            end else begin
              pool_q[0] <= min;
              pool_q[1] <= midl;
              pool_q[2] <= midh;
              pool_q[3] <= max;
              d0_q      <= dig0;
              d1_q      <= dig1;
              d2_q      <= perm[0];
              k_q       <= 2'd0;
              busy_q    <= 1'b1;
              state_q   <= S_RUN;
            end
          end
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;
  assign a    = a_q;
  assign b    = b_q;
  assign c    = c_q;
  assign d    = d_q;

endmodule

// File: tb/tb_sort_perm_unsorter.sv
// Scoreboard bench for sort_perm_unsorter: stimulus pushes expected results,
// a negedge monitor pops and checks them whenever done or err is presented.
module tb_sort_perm_unsorter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [1:0] min = '0, midl = '0, midh = '0, max = '0;
  logic [4:0] perm = '0;
  logic       busy, done, err;
  logic [1:0] a, b, c, d;

  sort_perm_unsorter #(.W(2)) dut (
    .clk(clk), .rst(rst), .start(start),
    .min(min), .midl(midl), .midh(midh), .max(max), .perm(perm),
    .busy(busy), .done(done), .err(err),
    .a(a), .b(b), .c(c), .d(d)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_err;
    int         due;
    logic [1:0] ea, eb, ec, ed;
    bit         rec;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   busy_run = 0;
  int   n_distinct = 0;
  bit   seen [256];
  logic [1:0] last_a = '0, last_b = '0, last_c = '0, last_d = '0;

  // Hand-derived Lehmer permutations of (0,1,2,3); one hex nibble per output a,b,c,d.
  localparam logic [15:0] TAB [24] = '{
    16'h0123, 16'h0132, 16'h0213, 16'h0231, 16'h0312, 16'h0321,
    16'h1023, 16'h1032, 16'h1203, 16'h1230, 16'h1302, 16'h1320,
    16'h2013, 16'h2031, 16'h2103, 16'h2130, 16'h2301, 16'h2310,
    16'h3012, 16'h3021, 16'h3102, 16'h3120, 16'h3201, 16'h3210
  };

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (rst) begin
      if (busy) busy_run++;
      if (done || err) begin
        if (sb.size() == 0) begin
          chk("unexpected_event", {30'd0, done, err}, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("event_kind_err", int'(err), int'(e.is_err));
          chk("event_kind_done", int'(done), int'(!e.is_err));
          chk("event_cycle", cyc, e.due);
          chk("out_a", int'(a), int'(e.ea));
          chk("out_b", int'(b), int'(e.eb));
          chk("out_c", int'(c), int'(e.ec));
          chk("out_d", int'(d), int'(e.ed));
          if (!e.is_err) chk("busy_cycles", busy_run, 4);
          busy_run = 0;
          if (e.rec) begin
            int code;
            int oh;
            code = {24'd0, a, b, c, d};
            if (!seen[code]) n_distinct++;
            seen[code] = 1'b1;
            oh = (1 << a) | (1 << b) | (1 << c) | (1 << d);
            chk("sort_back", oh, 15);
          end
        end
      end
    end
  end

  task automatic issue(input logic [1:0] mn, ml, mh, mx, input logic [4:0] p,
                       input logic [15:0] expv, input bit rec);
    exp_t e;
    logic [15:0] v;
    @(negedge clk);
    min = mn; midl = ml; midh = mh; max = mx; perm = p; start = 1'b1;
    v = expv;
    e.is_err = (p >= 5'd24);
    e.rec    = rec;
    if (e.is_err) begin
      e.due = cyc + 1;
      e.ea = last_a; e.eb = last_b; e.ec = last_c; e.ed = last_d;
    end else begin
      e.due = cyc + 5;
      e.ea = v[13:12]; e.eb = v[9:8]; e.ec = v[5:4]; e.ed = v[1:0];
      last_a = e.ea; last_b = e.eb; last_c = e.ec; last_d = e.ed;
    end
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    min = 2'(~mn); midl = 2'(~ml); midh = 2'(~mh); max = 2'(~mx); perm = 5'd31;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 30) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", sb.size(), 0);
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [15:0] tv;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_abcd", int'({a, b, c, d}), 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Identity, reverse, mixed
    issue(2'd0, 2'd1, 2'd2, 2'd3, 5'd0, 16'h0123, 1'b0); drain();
    issue(2'd0, 2'd1, 2'd2, 2'd3, 5'd23, 16'h3210, 1'b0); drain();
    issue(2'd0, 2'd1, 2'd2, 2'd3, 5'd9, 16'h1230, 1'b0); drain();

    // Duplicates operate on positions
    issue(2'd1, 2'd1, 2'd2, 2'd2, 5'd23, 16'h2211, 1'b0); drain();

    // Illegal perm: err pulse, outputs keep prior values
    issue(2'd0, 2'd1, 2'd2, 2'd3, 5'd24, 16'h0000, 1'b0); drain();
    issue(2'd3, 2'd2, 2'd1, 2'd0, 5'd31, 16'h0000, 1'b0); drain();

    // Start re-pulsed mid-RUN with different data is ignored
    issue(2'd0, 2'd1, 2'd2, 2'd3, 5'd9, 16'h1230, 1'b0);
    start = 1'b1; perm = 5'd0; min = 2'd3; midl = 2'd3; midh = 2'd3; max = 2'd3;
    @(negedge clk);
    start = 1'b0;
    drain();

    // Full sweep
    for (int p = 0; p < 24; p++) begin
      tv = TAB[p];
      issue(2'd0, 2'd1, 2'd2, 2'd3, 5'(p), tv, 1'b1);
      drain();
    end
    chk("sweep_distinct", n_distinct, 24);

    // Reset mid-operation
    issue(2'd0, 2'd1, 2'd2, 2'd3, 5'd23, 16'h3210, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_abcd", int'({a, b, c, d}), 0);
    sb.delete();
    busy_run = 0;
    last_a = '0; last_b = '0; last_c = '0; last_d = '0;
    repeat (6) @(negedge clk);
    chk("abort_no_done", int'(done), 0);
    chk("abort_hold_abcd", int'({a, b, c, d}), 0);
    rst = 1'b1;
    issue(2'd0, 2'd1, 2'd2, 2'd3, 5'd0, 16'h0123, 1'b0); drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
